// File: rtl/led_status_driver.sv
// LED status driver: synchronised switch mirror, free-running slow/fast blink,
// and an alarm indicator FSM (IDLE/RING/ACKED) with an auto-silence timeout.
module led_status_driver #(
    parameter int unsigned NUM_SW          = 5,
    parameter int unsigned BLINK_DIV       = 25000000,
    parameter int unsigned TIMEOUT_PERIODS = 60
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_SW-1:0] sw,
    input  logic              alarm,
    input  logic              alarm_ack,
    input  logic [1:0]        mode,
    output logic [NUM_SW-1:0] led_sw,
    output logic              led_blink,
    output logic              led_alarm,
    output logic              alarm_active
);

    localparam int unsigned PRESC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned TMO_W   = 8;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(BLINK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_HALF = PRESC_W'((BLINK_DIV / 2) - 1);
    localparam logic [TMO_W-1:0]   TMO_LIMIT  = TMO_W'(TIMEOUT_PERIODS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RING  = 2'd1,
        ST_ACKED = 2'd2
    } state_t;

    logic [NUM_SW-1:0]  r_sw_meta;
    logic [NUM_SW-1:0]  r_sw_sync;
    logic [PRESC_W-1:0] r_presc;
    logic               r_blink;
    logic               r_fast;
    logic               r_alarm_q;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMO_W-1:0]   r_tmo;
    logic [TMO_W-1:0]   w_tmo_nxt;

    logic w_presc_wrap;
    logic w_presc_half;
    logic w_blink_fall;
    logic w_rise;

    assign w_presc_wrap = (r_presc == PRESC_LAST);
    assign w_presc_half = (r_presc == PRESC_HALF);
    assign w_blink_fall = w_presc_wrap & r_blink;
    assign w_rise       = alarm & ~r_alarm_q;

    // Two-flop synchroniser for the asynchronous slide switches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    assign led_sw = r_sw_sync;

    // Free-running prescaler and blink generators; never re-phased by the FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_blink <= 1'b0;
            r_fast  <= 1'b0;
        end else begin
            if (w_presc_wrap) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PRESC_W'(1);
            end
            if (w_presc_wrap) begin
                r_blink <= ~r_blink;
            end
            if (w_presc_wrap || w_presc_half) begin
                r_fast <= ~r_fast;
            end
        end
    end

    assign led_blink = r_blink;

    // State, timeout counter and alarm edge-detect registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_tmo     <= '0;
            r_alarm_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tmo     <= w_tmo_nxt;
            r_alarm_q <= alarm;
        end
    end

    // Next-state logic: alarm release outranks ack and timeout in RING
    always_comb begin
        w_state_nxt = r_state;
        w_tmo_nxt   = r_tmo;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_RING;
                    w_tmo_nxt   = '0;
                end
            end
            ST_RING: begin
                if (!alarm) begin
                    w_state_nxt = ST_IDLE;
                end else if (alarm_ack || (r_tmo >= TMO_LIMIT)) begin
                    w_state_nxt = ST_ACKED;
                end else if (w_blink_fall && (r_tmo < TMO_LIMIT)) begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            ST_ACKED: begin
                if (!alarm) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign alarm_active = (r_state == ST_RING);

    // Pattern select follows mode immediately; only the state gates it
    always_comb begin
        led_alarm = 1'b0;
        if (r_state == ST_RING) begin
            case (mode)
                2'b00:   led_alarm = r_blink;
                2'b01:   led_alarm = r_fast;
                2'b10:   led_alarm = 1'b1;
                default: led_alarm = 1'b0;
            endcase
        end
    end

endmodule
